// File: rtl/pwm_irq_scheduler.sv
// rtl/pwm_irq_scheduler.sv - round-robin interrupt scheduler with holdoff for PWM interrupt matrices
//
// Latches rising edges of per-source triggers as pending flags, picks one
// pending and unmasked source at a time in round-robin order, raises irq with
// its ID until the CPU acknowledges, then enforces a programmable idle gap
// before the next interrupt.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   src_event  source trigger levels; a rising edge sets pending
//   src_mask   1 = source eligible for arbitration
//   sw_clear   write-one-to-clear of pending and overrun (one-cycle pulse)
//   holdoff    idle cycles required after an ack before the next irq
//   int_ack    CPU acknowledge pulse
//   irq        interrupt request to the PS
//   irq_id     ID of the source being serviced; valid while irq=1
//   pending    latched pending flags
//   overrun    sticky; edge arrived while that source was already pending
//   busy       high whenever the scheduler is not idle
module pwm_irq_scheduler #(
  parameter int N_SRC     = 8,
  parameter int ID_W      = 3,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     src_event,
  input  logic [N_SRC-1:0]     src_mask,
  input  logic [N_SRC-1:0]     sw_clear,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 int_ack,
  output logic                 irq,
  output logic [ID_W-1:0]      irq_id,
  output logic [N_SRC-1:0]     pending,
  output logic [N_SRC-1:0]     overrun,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARB    = 2'd1;
  localparam logic [1:0] ST_ASSERT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  logic [1:0]           state;
  logic [N_SRC-1:0]     src_d;
  logic [N_SRC-1:0]     edges;
  logic [N_SRC-1:0]     eligible;
  logic [N_SRC-1:0]     ack_clr;
  logic                 ack_hit;
  logic [ID_W-1:0]      last_id;
  logic [ID_W-1:0]      next_id;
  logic [ID_W-1:0]      cand;
  logic                 found;
  logic [HOLDOFF_W-1:0] count;

  assign edges    = src_event & ~src_d;
  assign eligible = pending & src_mask;
  assign ack_hit  = (state == ST_ASSERT) && int_ack;

  assign irq  = (state == ST_ASSERT);
  assign busy = (state != ST_IDLE);

  // One-hot of the source whose pending flag the ack retires this cycle.
  always_comb begin
    ack_clr = '0;
    if (ack_hit) begin
      ack_clr[irq_id] = 1'b1;
    end
  end

  // Round-robin search starting just after the last acknowledged source.
  always_comb begin
    found   = 1'b0;
    next_id = '0;
    cand    = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = ID_W'((int'(last_id) + k) % N_SRC);
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        next_id = cand;
      end
    end
  end

  // Edge register loads during reset too, so a level already high at reset
  // release is not seen as an edge.
  always_ff @(posedge clk) begin
    src_d <= src_event;
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (sw_clear[i]) begin
          pending[i] <= 1'b0;
          overrun[i] <= 1'b0;
        end else if (edges[i]) begin
          pending[i] <= 1'b1;
          // An edge coinciding with the ack of this source re-arms it cleanly.
          if (pending[i] && !ack_clr[i]) begin
            overrun[i] <= 1'b1;
          end
        end else if (ack_clr[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      irq_id  <= '0;
      last_id <= ID_W'(N_SRC - 1);
      count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state <= ST_ARB;
          end
        end
        ST_ARB: begin
          // Candidates may have been cleared or masked since IDLE looked.
          if (found) begin
            irq_id <= next_id;
            state  <= ST_ASSERT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ASSERT: begin
          if (int_ack) begin
            last_id <= irq_id;
            count   <= '0;
            state   <= (holdoff == '0) ? ST_IDLE : ST_HOLD;
          end else if (sw_clear[irq_id]) begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (count == holdoff - HOLDOFF_W'(1)) begin
            state <= ST_IDLE;
          end else begin
            count <= count + HOLDOFF_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_irq_scheduler.sv
// tb/tb_pwm_irq_scheduler.sv - self-checking bench for pwm_irq_scheduler
module tb_pwm_irq_scheduler;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src_event;
  logic [N-1:0]  src_mask;
  logic [N-1:0]  sw_clear;
  logic [HW-1:0] holdoff;
  logic          int_ack;
  logic          irq;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overrun;
  logic          busy;

  pwm_irq_scheduler #(.N_SRC(N), .ID_W(IW), .HOLDOFF_W(HW)) dut (
    .clk(clk), .reset(reset), .src_event(src_event), .src_mask(src_mask),
    .sw_clear(sw_clear), .holdoff(holdoff), .int_ack(int_ack),
    .irq(irq), .irq_id(irq_id), .pending(pending), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending/overrun from the edge rules, scheduling from
  // timestamps (next cycle at which an idle scheduler may look for work).
  logic [N-1:0] m_pend = '0, m_ovr = '0, m_prev = '0;
  logic [N-1:0] old_pend, elig;
  bit           m_serv = 0, m_arb = 0, ack_hit, found, e, ackc;
  int           m_sid = 0, m_last = N - 1, j;
  longint       cyc = 0, m_look = 0;
  bit           cmp_en = 0;

  function automatic bit m_busy();
    return m_serv || m_arb || (cyc + 1 < m_look);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_pend = '0; m_ovr = '0; m_serv = 0; m_arb = 0;
      m_sid = 0; m_last = N - 1; m_look = cyc + 1;
      m_prev = src_event;
    end else begin
      old_pend = m_pend;
      elig     = old_pend & src_mask;
      ack_hit  = m_serv && int_ack;
      for (int i = 0; i < N; i++) begin
        e    = src_event[i] && !m_prev[i];
        ackc = ack_hit && (m_sid == i);
        if (sw_clear[i]) begin
          m_pend[i] = 1'b0; m_ovr[i] = 1'b0;
        end else if (e) begin
          if (old_pend[i] && !ackc) m_ovr[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (ackc) begin
          m_pend[i] = 1'b0;
        end
      end
      m_prev = src_event;
      if (m_serv) begin
        if (ack_hit) begin
          m_serv = 0; m_last = m_sid; m_look = cyc + longint'(holdoff) + 1;
        end else if (sw_clear[m_sid]) begin
          m_serv = 0; m_look = cyc + 1;
        end
      end else if (m_arb) begin
        m_arb = 0;
        found = 0;
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (!found && elig[j]) begin found = 1; m_sid = j; end
        end
        if (found) m_serv = 1;
        else m_look = cyc + 1;
      end else if (cyc >= m_look && |elig) begin
        m_arb = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("irq", 32'(irq), 32'(m_serv));
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (m_serv) chk("irq_id", 32'(irq_id), 32'(m_sid));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src_event = src_event | m;
    step();
    src_event = src_event & ~m;
    step();
  endtask

  task automatic wait_irq(input string name);
    int w = 0;
    while (irq !== 1'b1 && w < 40) begin step(); w++; end
    chk({name, "_irq"}, 32'(irq), 32'd1);
  endtask

  task automatic serve(input int exp_id, input int dly, input string name);
    wait_irq(name);
    chk({name, "_id"}, 32'(irq_id), 32'(exp_id));
    repeat (dly) step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  int hi, low;

  initial begin
    reset = 1'b1; src_event = 8'h04; src_mask = 8'hFF; sw_clear = '0;
    holdoff = '0; int_ack = 1'b0;
    step();
    cmp_en = 1;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_busy", 32'(busy), 0);
    step(); step();
    reset = 1'b0;
    hi = 0;
    repeat (20) begin step(); if (irq !== 1'b0) hi++; end
    chk("rst_no_irq", 32'(hi), 0);
    chk("rst_pend", 32'(pending), 0);
    src_event = '0;
    step();

    // Single edge on source 3: latency and ack.
    src_event = 8'h08;
    step();
    src_event = '0;
    chk("t2_pend_k", 32'(pending), 32'h08);
    chk("t2_irq_k", 32'(irq), 0);
    step();
    chk("t2_irq_k1", 32'(irq), 0);
    step();
    chk("t2_irq_k2", 32'(irq), 1);
    chk("t2_id_k2", 32'(irq_id), 3);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("t2_irq_ack", 32'(irq), 0);
    chk("t2_pend_ack", 32'(pending), 0);

    // Round-robin order.
    pulse(8'h80); serve(7, 0, "prep7");
    pulse(8'h62);
    serve(1, 2, "t3a"); serve(5, 2, "t3b"); serve(6, 2, "t3c");
    pulse(8'h02); serve(1, 0, "t3d");
    pulse(8'h22); serve(5, 0, "t3e"); serve(1, 0, "t3f");

    // Holdoff of 10 cycles between acks.
    pulse(8'h80); serve(7, 0, "t4p");
    pulse(8'h05);
    wait_irq("t4a");
    chk("t4a_id", 32'(irq_id), 0);
    holdoff = 16'd10;
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    low = 0;
    while (irq !== 1'b1 && low < 40) begin low++; step(); end
    chk("t4_low_cycles", 32'(low), 12);
    chk("t4b_id", 32'(irq_id), 2);
    holdoff = '0;
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;

    // Overrun, sw_clear and edge-in-ack-cycle.
    src_mask = 8'hEF;
    pulse(8'h10);
    chk("t5_pend1", 32'(pending), 32'h10);
    chk("t5_ovr1", 32'(overrun), 0);
    pulse(8'h10);
    chk("t5_ovr2", 32'(overrun), 32'h10);
    sw_clear = 8'h10;
    step();
    sw_clear = '0;
    chk("t5_clr_pend", 32'(pending), 0);
    chk("t5_clr_ovr", 32'(overrun), 0);
    src_mask = 8'hFF;
    pulse(8'h10);
    wait_irq("t5c");
    chk("t5c_id", 32'(irq_id), 4);
    int_ack = 1'b1; src_event = 8'h10;
    step();
    int_ack = 1'b0; src_event = '0;
    chk("t5_ackedge_pend", 32'(pending), 32'h10);
    chk("t5_ackedge_ovr", 32'(overrun), 0);
    serve(4, 0, "t5r");

    // Masking and reset during ASSERT.
    src_mask = 8'hFE;
    pulse(8'h01);
    repeat (4) step();
    chk("t6_masked_irq", 32'(irq), 0);
    chk("t6_masked_pend", 32'(pending), 32'h01);
    src_mask = 8'hFF;
    step();
    chk("t6_unmask1", 32'(irq), 0);
    step();
    chk("t6_unmask2", 32'(irq), 1);
    chk("t6_unmask_id", 32'(irq_id), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_irq", 32'(irq), 0);
    chk("t6_rst_pend", 32'(pending), 0);
    chk("t6_rst_busy", 32'(busy), 0);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) src_event[b] = ~src_event[b];
      if ($urandom_range(0, 63) == 0) src_mask = N'($urandom);
      sw_clear = ($urandom_range(0, 15) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      int_ack  = (sw_clear == '0) && ($urandom_range(0, 3) == 0);
      if (!m_busy() && $urandom_range(0, 31) == 0) holdoff = HW'($urandom_range(0, 6));
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; int_ack = 1'b0; sw_clear = '0;
    repeat (5) step();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_irq_scheduler.md
Name: pwm_irq_scheduler

Overview:
- Collects the per-group interrupt triggers produced by the PWM interrupt matrices (one bit per source).
- Latches each trigger as a pending flag and arbitrates round-robin among pending, unmasked sources.
- Presents one interrupt at a time to the PS with its source ID, then waits for the CPU acknowledge.
- Enforces a programmable minimum idle time between consecutive interrupts so the PS is not flooded at high PWM carrier rates.

Parameters:
N_SRC, 8, number of interrupt sources
ID_W, 3, width of source ID; must satisfy 2**ID_W >= N_SRC
HOLDOFF_W, 16, width of the holdoff counter and the holdoff input

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
src_event  in  N_SRC  source trigger levels; a rising edge sets pending
src_mask  in  N_SRC  1 = source eligible for arbitration
sw_clear  in  N_SRC  write-one-to-clear of pending and overrun, one-cycle pulse
holdoff  in  HOLDOFF_W  idle cycles required after an ack before the next irq
int_ack  in  1  CPU acknowledge pulse
irq  out  1  interrupt request to the PS
irq_id  out  ID_W  ID of the source being serviced; valid while irq=1
pending  out  N_SRC  latched pending flags
overrun  out  N_SRC  sticky; set by an edge that arrives while that source is already pending
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: irq=0, irq_id=0, pending=0, overrun=0, busy=0.
  - Internal: state=IDLE, last_id=N_SRC-1, so the first grant goes to source 0.
  - Edge register: src_d loads src_event, so a level already high at reset release is not an edge.
  - Reset asserted mid-operation aborts immediately to this state; no ack is required.
- Edge detect:
  - edge[i] = src_event[i] & ~src_d[i].
  - src_d is updated every cycle.
- Pending update, per source, priority high to low:
  1. sw_clear[i]: clears pending and overrun.
  2. edge[i]: sets pending. If pending was already 1 and is not being cleared by ack this cycle, overrun[i] is also set.
  3. Ack clear of the serviced ID.
  - An edge in the same cycle as the ack clear leaves pending=1 and does not set overrun.
- Masking:
  - Masked sources still latch pending and overrun; they are excluded only from arbitration.
  - Unmasking a pending source makes it eligible the next cycle.
- FSM (state is registered; irq and busy are decoded from registered state):
  - IDLE: if |(pending & src_mask), go to ARB.
  - ARB, one cycle:
    - Search IDs last_id+1 .. wrapping mod N_SRC for the first with pending & src_mask.
    - Register that ID into irq_id and go to ASSERT.
    - If no candidate remains (cleared or masked meanwhile), return to IDLE.
  - ASSERT: irq=1.
    - On int_ack: clear pending[irq_id], set last_id=irq_id. Go to HOLD with count=0, or straight to IDLE if holdoff==0.
    - If sw_clear[irq_id] arrives, abort to IDLE without holdoff; last_id is unchanged.
    - Clearing src_mask[irq_id] does not retract irq.
    - int_ack in any state other than ASSERT is ignored.
  - HOLD: count increments each cycle; when count==holdoff-1, go to IDLE. irq=0 throughout.
- Latency:
  - Rising edge sampled at clock k: pending=1 after k, ARB after k+1, irq=1 after k+2.
  - Ack sampled at clock a: irq=0 after a.
  - The next irq rises no earlier than after clock a+holdoff+2.
- Fairness: with all sources continuously pending and unmasked, grants cycle 0,1,...,N_SRC-1,0, with no repeats.
- Width rules: counter is HOLDOFF_W bits; holdoff = 2**HOLDOFF_W-1 must terminate without wrap.

Test Plan:
- Reset release with src_event=8'h04 held high -> no pending, irq stays 0 for 20 cycles.
- Rising edge on src 3 at clock k, mask=8'hFF, holdoff=0 -> irq=1 and irq_id=3 after clock k+2. Ack at clock a -> irq=0 after a; pending=0.
- Simultaneous edges on sources 1, 5, 6, holdoff=0, ack 3 cycles after each irq -> irq_id sequence 1, 5, 6. A subsequent edge on source 1 with source 5 re-pending -> 5 is served before 1.
- holdoff=10, sources 0 and 2 pending, ack at clock a -> irq low for exactly 12 cycles, then irq_id=2.
- While source 4 is pending, a second edge on 4 -> overrun=8'h10. sw_clear=8'h10 -> pending[4]=0 and overrun=0. An edge in the ack cycle -> pending stays 1, overrun=0.
- mask=8'hFE with source 0 pending -> no irq. Unmasking 0 -> irq_id=0 two cycles later. Reset pulsed during ASSERT -> irq=0 after that clock and pending=0.
